// File: rtl/red_ctrl_pkg.sv
// Shared types and encodings for the reduced RV32 multi-cycle controller.
// Contents: FSM state enum, instruction-class enum, decoded-field struct,
// opcode / ALUctrl / ResultSrc constants and the combinational decode helper.
package red_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Instruction classes; R-type and addi share a sequence so they share a class.
  typedef enum logic [2:0] {
    K_ALU   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_BEQ   = 3'd3,
    K_BNE   = 3'd4,
    K_JAL   = 3'd5,
    K_ILL   = 3'd6
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] aluctrl;
    logic       alusrc;
  } dec_t;

  // Unsupported encodings come back as K_ILL with ALUctrl/ALUsrc at zero so a
  // NOP never presents a stray operation to the datapath.
  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.kind    = K_ILL;
    d.aluctrl = ALU_ADD;
    d.alusrc  = 1'b0;
    case (ir[6:0])
      OP_R: begin
        if (ir[31:25] == 7'h00) begin
          case (ir[14:12])
            3'b000:  begin d.kind = K_ALU; d.aluctrl = ALU_ADD; end
            3'b111:  begin d.kind = K_ALU; d.aluctrl = ALU_AND; end
            3'b110:  begin d.kind = K_ALU; d.aluctrl = ALU_OR;  end
            3'b010:  begin d.kind = K_ALU; d.aluctrl = ALU_SLT; end
            default: d.kind = K_ILL;
          endcase
        end else if (ir[31:25] == 7'h20 && ir[14:12] == 3'b000) begin
          d.kind    = K_ALU;
          d.aluctrl = ALU_SUB;
        end
      end
      OP_I: begin
        if (ir[14:12] == 3'b000) begin
          d.kind   = K_ALU;
          d.alusrc = 1'b1;
        end
      end
      OP_LOAD: begin
        if (ir[14:12] == 3'b010) begin
          d.kind   = K_LOAD;
          d.alusrc = 1'b1;
        end
      end
      OP_STORE: begin
        if (ir[14:12] == 3'b010) begin
          d.kind   = K_STORE;
          d.alusrc = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (ir[14:12] == 3'b000) begin
          d.kind    = K_BEQ;
          d.aluctrl = ALU_SUB;
        end else if (ir[14:12] == 3'b001) begin
          d.kind    = K_BNE;
          d.aluctrl = ALU_SUB;
        end
      end
      OP_JAL:  d.kind = K_JAL;
      default: d.kind = K_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch-side handshake between the instruction fetch unit and the controller.
//   instr_valid / instr : fetch presents an instruction word
//   instr_ready         : controller can accept (FETCH state)
//   PCWrite / PCSrc     : PC update strobe and select back to fetch
// master = fetch unit, slave = controller.
interface multicycle_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr;
  logic                  PCWrite;
  logic                  PCSrc;

  modport master (
    output instr_valid, instr,
    input  instr_ready, PCWrite, PCSrc
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, PCWrite, PCSrc
  );
endinterface

// File: rtl/multicycle_ctrl_imm_ext.sv
// imm_ext: combinational immediate generator for the latched instruction.
//   ir  in  DATA_WIDTH  latched instruction word (RV32 layout)
//   imm out DATA_WIDTH  sign-extended I/S/B/J immediate chosen by opcode,
//                       zero for opcodes without an immediate
module imm_ext
  import red_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] imm
);

  always_comb begin
    imm = '0;
    case (ir[6:0])
      OP_I, OP_LOAD: imm = {{20{ir[31]}}, ir[31:20]};
      OP_STORE:      imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:     imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_JAL:        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:       imm = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle sequencer for the reduced RV32 datapath.
// Accepts one instruction per handshake, holds it in IR until it retires and
// drives the regfile / ALU / datamem strobes one state at a time.
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   fetch (slave)          instr_valid/instr in, instr_ready/PCWrite/PCSrc out
//   Zero                   ALU zero flag (branch resolution)
//   rs1, rs2, rd           register indices from IR (DECODE..final state, else 0)
//   ImmOp                  sign-extended immediate from IR
//   ALUctrl, ALUsrc        ALU op and operand-B select
//   RegWrite, MemWrite     one-cycle write strobes in the final state
//   ResultSrc              00 ALU, 01 mem, 10 PC+4
//   busy                   controller is working on (or stuck on) an instruction
//   retired                retired-instruction count, wraps
//   illegal                only with ILLEGAL_TRAP_EN: unsupported encoding trapped
// Optional feature macro: ILLEGAL_TRAP_EN (trap on unsupported encodings
// instead of retiring them as NOPs).
//
// state  | meaning
// IDLE   | after reset, one cycle before accepting
// FETCH  | instr_ready=1, waiting for instr_valid
// DECODE | IR latched, fields presented
// EXEC   | ALU working; branch resolves and retires here
// MEM    | datamem access; sw retires here
// WB     | register writeback (R/addi/lw/jal, NOP)
// HALT   | unsupported encoding trapped, left only by reset
module multicycle_ctrl
  import red_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int ALUctrl_WIDTH = 3,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_ctrl_if.slave         fetch,
  input  logic                     Zero,
  output logic [ADDRESS_WIDTH-1:0] rs1,
  output logic [ADDRESS_WIDTH-1:0] rs2,
  output logic [ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic [ALUctrl_WIDTH-1:0] ALUctrl,
  output logic                     ALUsrc,
  output logic                     RegWrite,
  output logic                     MemWrite,
  output logic [1:0]               ResultSrc,
  output logic                     busy,
`ifdef ILLEGAL_TRAP_EN
  output logic                     illegal,
`endif
  output logic [CNT_WIDTH-1:0]     retired
);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] imm_raw;
  dec_t                  dec;
  logic                  active;
  logic                  instr_ready;
  logic                  pc_write;
  logic                  pc_src;

  assign dec = decode(ir);

  imm_ext #(.DATA_WIDTH(DATA_WIDTH)) u_imm_ext (
    .ir  (ir),
    .imm (imm_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH && fetch.instr_valid)
        ir <= fetch.instr;
      // PCWrite fires exactly once, in the retiring state
      if (pc_write)
        retired <= retired + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    ResultSrc   = RES_ALU;
    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        instr_ready = 1'b1;
        if (fetch.instr_valid)
          state_next = DECODE;
      end
      DECODE: begin
        case (dec.kind)
          K_JAL: state_next = WB;
`ifdef ILLEGAL_TRAP_EN
          K_ILL: state_next = HALT;
`else
          K_ILL: state_next = WB;
`endif
          default: state_next = EXEC;
        endcase
      end
      EXEC: begin
        case (dec.kind)
          K_LOAD, K_STORE: state_next = MEM;
          K_BEQ, K_BNE: begin
            pc_write   = 1'b1;
            pc_src     = (dec.kind == K_BEQ) ? Zero : !Zero;
            state_next = FETCH;
          end
          default: state_next = WB;
        endcase
      end
      MEM: begin
        if (dec.kind == K_STORE) begin
          MemWrite   = 1'b1;
          pc_write   = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = WB;
        end
      end
      WB: begin
        pc_write   = 1'b1;
        RegWrite   = (dec.kind != K_ILL);
        pc_src     = (dec.kind == K_JAL);
        if (dec.kind == K_LOAD)
          ResultSrc = RES_MEM;
        else if (dec.kind == K_JAL)
          ResultSrc = RES_PC4;
        state_next = FETCH;
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Decoded fields are shown only while an instruction is in flight so that
  // reset, IDLE, FETCH and HALT all present a quiet datapath.
  assign active  = (state == DECODE) || (state == EXEC) || (state == MEM) || (state == WB);
  assign rs1     = active ? ir[19:15] : '0;
  assign rs2     = active ? ir[24:20] : '0;
  assign rd      = active ? ir[11:7]  : '0;
  assign ImmOp   = active ? imm_raw   : '0;
  assign ALUctrl = active ? dec.aluctrl : '0;
  assign ALUsrc  = active ? dec.alusrc  : 1'b0;

  assign busy = (state != FETCH) && (state != IDLE);
`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == HALT);
`endif

  assign fetch.instr_ready = instr_ready;
  assign fetch.PCWrite     = pc_write;
  assign fetch.PCSrc       = pc_src;

endmodule
